// File: rtl/display_feeder.sv
// Buffers host characters, normalises them, and drains one byte per display write strobe.
// Latency: a byte pushed on edge N is presented after N and can be written on edge N+1.
// Backpressure: in_ready drops when the FIFO is full; bytes offered while full are dropped and flagged.

module display_feeder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clock,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered count, so a pop never frees room for a same-edge push
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full && !clr;
    assign do_pop   = pop_vld && !empty && !clr;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// Character feeder in front of the display TX register.
// Latency: one edge from push to disp_w_en; pop on the edge the display latches the byte.
// Backpressure: display stalls via disp_ready and the clock enables; producer stalls via in_ready.
module display_feeder #(
    parameter int DEPTH  = 16,
    parameter int UPCASE = 1
) (
    input  logic                     sys_clock,
    input  logic                     reset_n,
    input  logic                     pixel_clken,
    input  logic                     cpu_clken,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     disp_address,
    output logic                     disp_w_en,
    output logic [7:0]               disp_din,
    input  logic                     disp_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    logic       last_cr;
    logic       full;
    logic       empty;
    logic       is_cr;
    logic       is_lf;
    logic       drop_lf;
    logic       accept;
    logic       push_vld;
    logic       pop_vld;
    logic [7:0] norm_dat;

    assign is_cr   = (in_data[6:0] == 7'h0D);
    assign is_lf   = (in_data[6:0] == 7'h0A);
    assign drop_lf = last_cr && is_lf;

    always_comb begin
        norm_dat = in_data | 8'h80;
        if ((UPCASE != 0) && (in_data[6:0] >= 7'h61) && (in_data[6:0] <= 7'h7A)) begin
            norm_dat[5] = 1'b0;
        end
    end

    // accept covers both stored bytes and the LF swallowed after a CR
    assign accept   = in_valid && !full && !flush;
    assign push_vld = accept && !drop_lf;
    assign pop_vld  = pixel_clken && cpu_clken && disp_ready;

    display_feeder_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .clr       (flush),
        .push_vld  (push_vld),
        .push_dat  (norm_dat),
        .pop_vld   (pop_vld),
        .head_dat  (disp_din),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign in_ready     = !full;
    assign disp_w_en    = !empty;
    assign disp_address = 1'b0;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            last_cr  <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
            last_cr  <= 1'b0;
        end else begin
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                last_cr <= is_cr;
            end
        end
    end
endmodule
